data_sram_bridge: RTL

Data-side bus bridge placed directly downstream of the MEM stage. It turns MEM's single-cycle memory intent (ce/we/sel/size/addr/data) into a split-transaction SRAM-like request/response. It returns load data to MEM and raises a pipeline stall request until the access completes. It also maps kseg0/kseg1 addresses to physical addresses and absorbs responses orphaned by an exception flush.

---
 rtl/data_sram_bridge.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/data_sram_bridge.sv
// MEM-stage to split-transaction SRAM bridge: one outstanding access, kseg0/1 mapping, orphan-response drain.
// Latency: zero-wait access holds MEM 3 cycles (2 stalls); every bus wait cycle adds one stall via stallreq_o.
module data_sram_bridge #(
  parameter bit ADDR_MAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [1:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        mem_except_i,
  output logic [31:0] mem_rdata_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic        data_req_q, data_req_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        issue;
  logic        unused_sel;

  // Byte lanes are implied by size and address on this bus.
  assign unused_sel = ^mem_sel_i;

  function automatic logic [31:0] map_addr(input logic [31:0] va);
    if (ADDR_MAP_EN && (va[31:30] == 2'b10)) begin
      return {3'b000, va[28:0]};
    end
    return va;
  endfunction

  assign issue = mem_ce_i & ~mem_except_i & ~flush_i;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    data_req_d  = data_req_q;
    rbuf_d      = rbuf_q;
    stallreq_o  = 1'b0;
    mem_rdata_o = rbuf_q;

    case (state_q)
      S_IDLE: begin
        stallreq_o = issue;
        if (issue) begin
          req_d.wr    = mem_we_i;
          req_d.size  = mem_size_i;
          req_d.addr  = map_addr(mem_addr_i);
          req_d.wdata = mem_wdata_i;
          data_req_d  = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        stallreq_o = 1'b1;
        if (data_addr_ok) begin
          data_req_d = 1'b0;
          state_d    = flush_i ? S_DRAIN : S_WAIT;
        end else if (flush_i) begin
          // Never accepted by the slave, so the request can simply be withdrawn.
          data_req_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          mem_rdata_o = data_rdata;
          rbuf_d      = data_rdata;
          state_d     = (stall_i & ~flush_i) ? S_DONE : S_IDLE;
        end else begin
          stallreq_o = 1'b1;
          if (flush_i) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DONE: begin
        if (~stall_i | flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Hold any new access off until the orphaned response has been swallowed.
        stallreq_o = mem_ce_i & ~mem_except_i;
        if (data_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        data_req_d = 1'b0;
      end
    endcase

    if (rst) begin
      stallreq_o  = 1'b0;
      mem_rdata_o = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      data_req_q <= 1'b0;
      rbuf_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      data_req_q <= data_req_d;
      rbuf_q     <= rbuf_d;
    end
  end

  assign data_req   = data_req_q;
  assign data_wr    = req_q.wr;
  assign data_size  = req_q.size;
  assign data_addr  = req_q.addr;
  assign data_wdata = req_q.wdata;

endmodule
